// File: rtl/modbus_frame_ctrl.sv
// Modbus RTU receive frame controller. It frames on t3.5 silence, assembles bytes,
// runs a bit-serial CRC-16/Modbus, filters on address, and hands frames off via valid/ack.
module modbus_frame_ctrl #(
    parameter int         FRAME_BYTES = 7,
    parameter logic [7:0] SLAVE_ADDR  = 8'h01,
    parameter int         T35_CYCLES  = 80208,
    parameter int         CNT_W       = 17
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     RX_Byte_Done,
    input  logic [7:0]               RX_Byte,
    input  logic                     Frame_Ack,
    output logic                     RX_En_Sig,
    output logic [8*FRAME_BYTES-1:0] Frame_Data,
    output logic                     Frame_Valid,
    output logic                     Frame_Err,
    output logic [1:0]               Err_Code
);
    localparam int               IDX_W     = $clog2(FRAME_BYTES + 1);
    localparam logic [CNT_W-1:0] T35       = CNT_W'(T35_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_BYTES - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(FRAME_BYTES - 3);

    localparam logic [1:0] ERR_OVERRUN = 2'b00;
    localparam logic [1:0] ERR_SHORT   = 2'b01;
    localparam logic [1:0] ERR_CRC     = 2'b10;
    localparam logic [1:0] ERR_ADDR    = 2'b11;

    typedef enum logic [2:0] {SYNC, IDLE, RECV, CHECK, HOLD, RESYNC} state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] silence_cnt;
    logic             silent;
    logic [IDX_W-1:0] byte_cnt, wr_idx;
    logic             store_byte, overrun;
    logic [15:0]      crc;
    logic [7:0]       crc_data;
    logic [3:0]       bit_cnt;
    logic             crc_busy, crc_fb, crc_ok, addr_ok;
    logic             err_set, valid_set, valid_clr, rx_en_nxt;
    logic [1:0]       err_code_nxt;

    assign silent     = (silence_cnt == T35);
    assign crc_busy   = (bit_cnt != 4'd0);
    assign crc_fb     = crc[0] ^ crc_data[0];
    assign overrun    = (state == RECV) && RX_Byte_Done && crc_busy;
    assign store_byte = ((state == IDLE) || (state == RECV)) && RX_Byte_Done && !overrun;
    assign wr_idx     = (state == IDLE) ? '0 : byte_cnt;
    assign crc_ok     = (crc == {Frame_Data[8*(FRAME_BYTES-1) +: 8], Frame_Data[8*(FRAME_BYTES-2) +: 8]});
    assign addr_ok    = (Frame_Data[7:0] == SLAVE_ADDR) || (Frame_Data[7:0] == 8'h00);

    always_ff @(posedge CLK) begin
        if (!RSTn) state <= SYNC;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            SYNC, RESYNC: if (silent) next_state = IDLE;
            IDLE:         if (RX_Byte_Done) next_state = RECV;
            RECV: begin
                if (overrun)                                      next_state = RESYNC;
                else if (RX_Byte_Done && (byte_cnt == LAST_IDX)) next_state = CHECK;
                else if (!RX_Byte_Done && silent)                next_state = IDLE;
            end
            CHECK:        next_state = (crc_ok && addr_ok) ? HOLD : RESYNC;
            HOLD:         if (Frame_Ack) next_state = SYNC;
            default:      next_state = SYNC;
        endcase
    end

    // Only bytes ahead of the two CRC bytes are folded; the CRC bytes are compared in CHECK.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            silence_cnt <= '0;
            byte_cnt    <= '0;
            crc         <= 16'hFFFF;
            crc_data    <= '0;
            bit_cnt     <= '0;
            Frame_Data  <= '0;
        end else begin
            if (RX_Byte_Done)  silence_cnt <= '0;
            else if (!silent)  silence_cnt <= silence_cnt + 1'b1;

            if (store_byte) begin
                byte_cnt <= wr_idx + 1'b1;
                for (int k = 0; k < FRAME_BYTES; k++) begin
                    if (wr_idx == IDX_W'(k)) Frame_Data[8*k +: 8] <= RX_Byte;
                end
            end

            if (store_byte && (wr_idx <= LAST_DATA)) begin
                crc      <= (state == IDLE) ? 16'hFFFF : crc;
                crc_data <= RX_Byte;
                bit_cnt  <= 4'd8;
            end else if (crc_busy) begin
                crc      <= {1'b0, crc[15:1]} ^ (crc_fb ? 16'hA001 : 16'h0000);
                crc_data <= {1'b0, crc_data[7:1]};
                bit_cnt  <= bit_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        err_set      = 1'b0;
        err_code_nxt = ERR_OVERRUN;
        valid_set    = 1'b0;
        valid_clr    = 1'b0;
        case (state)
            RECV: begin
                if (overrun) begin
                    err_set      = 1'b1;
                    err_code_nxt = ERR_OVERRUN;
                end else if (!RX_Byte_Done && silent) begin
                    err_set      = 1'b1;
                    err_code_nxt = ERR_SHORT;
                end
            end
            CHECK: begin
                if (!crc_ok) begin
                    err_set      = 1'b1;
                    err_code_nxt = ERR_CRC;
                end else if (!addr_ok) begin
                    err_set      = 1'b1;
                    err_code_nxt = ERR_ADDR;
                end else begin
                    valid_set    = 1'b1;
                end
            end
            HOLD:    valid_clr = Frame_Ack;
            default: ;
        endcase
        rx_en_nxt = !((next_state == CHECK) || (next_state == HOLD));
    end

    // Outputs are registered so that every output reads 0 straight after a reset edge.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            RX_En_Sig   <= 1'b0;
            Frame_Valid <= 1'b0;
            Frame_Err   <= 1'b0;
            Err_Code    <= 2'b00;
        end else begin
            RX_En_Sig <= rx_en_nxt;
            Frame_Err <= err_set;
            if (err_set)        Err_Code    <= err_code_nxt;
            if (valid_set)      Frame_Valid <= 1'b1;
            else if (valid_clr) Frame_Valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_modbus_frame_ctrl.sv
// Directed bench for modbus_frame_ctrl: an 8-byte instance for the reference frame and a
// 7-byte instance for the error, framing, overrun and reset scenarios.
module tb_modbus_frame_ctrl;
    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  rx_byte;
    logic        done8, done7, ack8, ack7;
    logic        rx_en8, valid8, err8, rx_en7, valid7, err7;
    logic [1:0]  code8, code7;
    logic [63:0] data8;
    logic [55:0] data7;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    modbus_frame_ctrl #(.FRAME_BYTES(8), .SLAVE_ADDR(8'h01), .T35_CYCLES(200), .CNT_W(8)) dut8 (
        .CLK(clk), .RSTn(rstn), .RX_Byte_Done(done8), .RX_Byte(rx_byte), .Frame_Ack(ack8),
        .RX_En_Sig(rx_en8), .Frame_Data(data8), .Frame_Valid(valid8), .Frame_Err(err8), .Err_Code(code8));

    modbus_frame_ctrl #(.T35_CYCLES(200), .CNT_W(8)) dut7 (
        .CLK(clk), .RSTn(rstn), .RX_Byte_Done(done7), .RX_Byte(rx_byte), .Frame_Ack(ack7),
        .RX_En_Sig(rx_en7), .Frame_Data(data7), .Frame_Valid(valid7), .Frame_Err(err7), .Err_Code(code7));

    // Byte-wise reference CRC-16/Modbus over the five payload bytes, byte 0 at [7:0].
    function automatic logic [15:0] crc16(input logic [39:0] p);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            c = c ^ {8'h00, p[8*i +: 8]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns 1 time unit after the edge that samples the byte.
    task automatic send_byte(input bit to8, input logic [7:0] b);
        rx_byte = b;
        if (to8) done8 = 1'b1; else done7 = 1'b1;
        @(posedge clk);
        #1;
        done8 = 1'b0;
        done7 = 1'b0;
    endtask

    task automatic send_frame7(input logic [39:0] p, input logic [15:0] c);
        logic [55:0] f;
        f = {c[15:8], c[7:0], p};
        for (int i = 0; i < 7; i++) begin
            send_byte(1'b0, f[8*i +: 8]);
            if (i != 6) idle(49);
        end
    endtask

    task automatic ack_dut7();
        ack7 = 1'b1;
        @(posedge clk);
        #1;
        ack7 = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if ({rx_en8, valid8, err8, code8} !== 5'b0) begin miscompares++; $display("[TB] FAIL reset_ctl8: got %b want 00000", {rx_en8, valid8, err8, code8}); end
        vectors++; if (data8 !== 64'h0) begin miscompares++; $display("[TB] FAIL reset_data8: got %h want 0", data8); end
        vectors++; if ({rx_en7, valid7, err7, code7} !== 5'b0) begin miscompares++; $display("[TB] FAIL reset_ctl7: got %b want 00000", {rx_en7, valid7, err7, code7}); end
        rstn = 1'b1;
        idle(1);
        vectors++; if (rx_en7 !== 1'b1) begin miscompares++; $display("[TB] FAIL sync_rx_en: got %b want 1", rx_en7); end
    endtask

    task automatic test_frame8();
        logic [63:0] f;
        f = 64'hCDC5_0A00_0000_0301;
        idle(300);
        for (int i = 0; i < 8; i++) begin
            send_byte(1'b1, f[8*i +: 8]);
            if (i != 7) idle(49);
        end
        vectors++; if (valid8 !== 1'b0) begin miscompares++; $display("[TB] FAIL f8_valid_t: got %b want 0", valid8); end
        idle(1);
        vectors++; if ({valid8, err8} !== 2'b10) begin miscompares++; $display("[TB] FAIL f8_valid_t1: got %b want 10", {valid8, err8}); end
        vectors++; if (data8 !== f) begin miscompares++; $display("[TB] FAIL f8_data: got %h want %h", data8, f); end
        idle(10);
        vectors++; if ({valid8, rx_en8} !== 2'b10) begin miscompares++; $display("[TB] FAIL f8_hold: got %b want 10", {valid8, rx_en8}); end
        ack8 = 1'b1;
        idle(1);
        ack8 = 1'b0;
        vectors++; if ({valid8, rx_en8} !== 2'b01) begin miscompares++; $display("[TB] FAIL f8_ack: got %b want 01", {valid8, rx_en8}); end
    endtask

    task automatic test_crc_error();
        logic [39:0] p, pf;
        logic [15:0] c;
        p  = {8'h12, 8'h01, 8'h00, 8'h06, 8'h00};
        pf = p ^ 40'h00_0100_0000;
        c  = crc16(p);
        idle(250);
        send_frame7(p, c);
        idle(1);
        vectors++; if ({valid7, err7} !== 2'b10) begin miscompares++; $display("[TB] FAIL bcast_valid: got %b want 10", {valid7, err7}); end
        vectors++; if (data7 !== {c[15:8], c[7:0], p}) begin miscompares++; $display("[TB] FAIL bcast_data: got %h want %h", data7, {c[15:8], c[7:0], p}); end
        ack_dut7();
        idle(250);
        send_frame7(pf, c);
        idle(1);
        vectors++; if ({valid7, err7, code7} !== 4'b0110) begin miscompares++; $display("[TB] FAIL crc_err: got %b want 0110", {valid7, err7, code7}); end
        idle(1);
        vectors++; if ({valid7, err7} !== 2'b00) begin miscompares++; $display("[TB] FAIL crc_err_pulse: got %b want 00", {valid7, err7}); end
        idle(250);
        send_frame7(p, c);
        idle(1);
        vectors++; if ({valid7, err7} !== 2'b10) begin miscompares++; $display("[TB] FAIL after_crc_err: got %b want 10", {valid7, err7}); end
        ack_dut7();
    endtask

    task automatic test_addr_mismatch();
        logic [39:0] p;
        p = {8'h12, 8'h01, 8'h00, 8'h06, 8'h05};
        idle(250);
        send_frame7(p, crc16(p));
        idle(1);
        vectors++; if ({valid7, err7, code7} !== 4'b0111) begin miscompares++; $display("[TB] FAIL addr_err: got %b want 0111", {valid7, err7, code7}); end
        idle(5);
        vectors++; if (valid7 !== 1'b0) begin miscompares++; $display("[TB] FAIL addr_no_valid: got %b want 0", valid7); end
    endtask

    task automatic test_overrun();
        idle(250);
        send_byte(1'b0, 8'h01);
        idle(49);
        send_byte(1'b0, 8'h03);
        idle(2);
        send_byte(1'b0, 8'h00);
        vectors++; if ({valid7, err7, code7} !== 4'b0100) begin miscompares++; $display("[TB] FAIL overrun: got %b want 0100", {valid7, err7, code7}); end
    endtask

    task automatic test_short_frame();
        logic [39:0] p;
        int first_err;
        logic [1:0] code_seen;
        p = {8'h0A, 8'h00, 8'h00, 8'h03, 8'h01};
        first_err = 0;
        code_seen = 2'b00;
        idle(250);
        send_byte(1'b0, 8'h01);
        idle(49);
        send_byte(1'b0, 8'h03);
        idle(49);
        send_byte(1'b0, 8'h00);
        // The counter reaches T35 200 cycles after the byte; the error registers one edge later.
        for (int k = 1; k <= 250; k++) begin
            @(posedge clk);
            #1;
            if (err7 && (first_err == 0)) begin
                first_err = k;
                code_seen = code7;
            end
        end
        vectors++; if (first_err != 201) begin miscompares++; $display("[TB] FAIL short_timing: got %0d want 201", first_err); end
        vectors++; if (code_seen !== 2'b01) begin miscompares++; $display("[TB] FAIL short_code: got %b want 01", code_seen); end
        send_frame7(p, crc16(p));
        idle(1);
        vectors++; if ({valid7, err7} !== 2'b10) begin miscompares++; $display("[TB] FAIL after_short: got %b want 10", {valid7, err7}); end
        ack_dut7();
    endtask

    task automatic test_reset_mid_frame();
        logic [39:0] p;
        logic [15:0] c;
        p = {8'h0A, 8'h00, 8'h00, 8'h03, 8'h01};
        c = crc16(p);
        idle(250);
        send_byte(1'b0, 8'h01);
        idle(49);
        send_byte(1'b0, 8'h03);
        idle(10);
        rstn = 1'b0;
        idle(1);
        rstn = 1'b1;
        vectors++; if ({rx_en7, valid7, err7, code7} !== 5'b0) begin miscompares++; $display("[TB] FAIL midreset_ctl: got %b want 00000", {rx_en7, valid7, err7, code7}); end
        vectors++; if (data7 !== 56'h0) begin miscompares++; $display("[TB] FAIL midreset_data: got %h want 0", data7); end
        idle(100);
        send_frame7(p, c);
        idle(1);
        vectors++; if ({valid7, err7} !== 2'b00) begin miscompares++; $display("[TB] FAIL midreset_sync: got %b want 00", {valid7, err7}); end
        vectors++; if (data7 !== 56'h0) begin miscompares++; $display("[TB] FAIL midreset_discard: got %h want 0", data7); end
        idle(250);
        send_frame7(p, c);
        idle(1);
        vectors++; if ({valid7, err7} !== 2'b10) begin miscompares++; $display("[TB] FAIL midreset_next: got %b want 10", {valid7, err7}); end
        vectors++; if (data7 !== {c[15:8], c[7:0], p}) begin miscompares++; $display("[TB] FAIL midreset_data2: got %h want %h", data7, {c[15:8], c[7:0], p}); end
        ack_dut7();
    endtask

    task automatic test_sync_discard();
        logic [39:0] p;
        logic [15:0] c;
        p = {8'h34, 8'h12, 8'h00, 8'h06, 8'h01};
        c = crc16(p);
        rstn = 1'b0;
        idle(1);
        rstn = 1'b1;
        idle(99);
        send_byte(1'b0, 8'h55);
        vectors++; if ({data7, err7} !== 57'h0) begin miscompares++; $display("[TB] FAIL sync_discard: got %h want 0", {data7, err7}); end
        idle(250);
        send_frame7(p, c);
        idle(1);
        vectors++; if ({valid7, err7} !== 2'b10) begin miscompares++; $display("[TB] FAIL sync_accept: got %b want 10", {valid7, err7}); end
        vectors++; if (data7 !== {c[15:8], c[7:0], p}) begin miscompares++; $display("[TB] FAIL sync_data: got %h want %h", data7, {c[15:8], c[7:0], p}); end
        ack_dut7();
        vectors++; if ({valid7, rx_en7} !== 2'b01) begin miscompares++; $display("[TB] FAIL sync_ack: got %b want 01", {valid7, rx_en7}); end
    endtask

    initial begin
        rstn    = 1'b0;
        rx_byte = 8'h00;
        done8   = 1'b0;
        done7   = 1'b0;
        ack8    = 1'b0;
        ack7    = 1'b0;
        test_reset();
        test_frame8();
        test_crc_error();
        test_addr_mismatch();
        test_overrun();
        test_short_frame();
        test_reset_mid_frame();
        test_sync_discard();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
